// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the memory port arbiter.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  typedef enum logic {SIDE_I, SIDE_D} arb_side_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Build option ARB_ROUND_ROBIN_EN: alternate winner on conflict (default: D side always wins).
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_err
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  logic       flush_pend_q, flush_pend_d;
  logic       win_d;

`ifdef ARB_ROUND_ROBIN_EN
  arb_side_t last_gnt_q, last_gnt_d;

  // On conflict the side not granted last wins; a lone requester always wins.
  assign win_d = d_req & (~i_req | (last_gnt_q == SIDE_I));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_gnt_q <= SIDE_I;
    else         last_gnt_q <= last_gnt_d;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == IDLE && mem_req && mem_ready) last_gnt_d = win_d ? SIDE_D : SIDE_I;
  end
`else
  assign win_d = d_req;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    i_gnt        = 1'b0;
    i_valid      = 1'b0;
    i_rdata      = '0;
    i_err        = 1'b0;
    d_gnt        = 1'b0;
    d_valid      = 1'b0;
    d_rdata      = '0;
    d_err        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;

    case (state_q)
      IDLE: begin
        mem_req = i_req | d_req;
        if (win_d) begin
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_wstrb = d_wstrb;
        end else begin
          mem_addr  = i_addr;
        end
        if (mem_req && mem_ready) begin
          if (win_d) begin
            d_gnt   = 1'b1;
            state_d = BUSY_D;
          end else begin
            i_gnt   = 1'b1;
            state_d = BUSY_I;
          end
        end
      end
      BUSY_I: begin
        if (mem_valid) begin
          state_d      = IDLE;
          flush_pend_d = 1'b0;
          // A flush pending or arriving with the response drops it.
          if (!flush_pend_q && !i_flush) begin
            i_valid = 1'b1;
            i_rdata = mem_rdata;
            i_err   = mem_err;
          end
        end else if (i_flush) begin
          flush_pend_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_valid) begin
          state_d = IDLE;
          d_valid = 1'b1;
          d_rdata = mem_rdata;
          d_err   = mem_err;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!resetn) begin
      i_gnt     = 1'b0;
      i_valid   = 1'b0;
      i_rdata   = '0;
      i_err     = 1'b0;
      d_gnt     = 1'b0;
      d_valid   = 1'b0;
      d_rdata   = '0;
      d_err     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = {STRB_W{1'b0}};
    end
  end

  // A response with nothing in flight is a memory-side protocol violation.
  a_no_idle_valid: assert property (@(posedge clk) disable iff (!resetn)
                                    !(state_q == IDLE && mem_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: responses are queued when memory returns them.
module tb_mem_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_req, i_flush, i_gnt, i_valid, i_err;
  logic [31:0] i_addr;
  logic [63:0] i_rdata;
  logic        d_req, d_we, d_gnt, d_valid, d_err;
  logic [31:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic [7:0]  d_wstrb;
  logic        mem_req, mem_we, mem_ready, mem_valid, mem_err;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  typedef struct packed {
    logic        side;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_valid(i_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Response monitor: every valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (resetn && (i_valid || d_valid)) begin
        checks++;
        if (i_valid && d_valid) begin
          errors++;
          $display("FAIL resp_both got i_valid=%0b d_valid=%0b exp one-hot", i_valid, d_valid);
        end else if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected got i_valid=%0b d_valid=%0b exp none", i_valid, d_valid);
        end else begin
          e = sb_q.pop_front();
          if (e.side) begin
            if (d_valid !== 1'b1 || d_rdata !== e.data || d_err !== e.err) begin
              errors++;
              $display("FAIL resp_d got v=%0b data=%h err=%0b exp v=1 data=%h err=%0b",
                       d_valid, d_rdata, d_err, e.data, e.err);
            end
          end else begin
            if (i_valid !== 1'b1 || i_rdata !== e.data || i_err !== e.err) begin
              errors++;
              $display("FAIL resp_i got v=%0b data=%h err=%0b exp v=1 data=%h err=%0b",
                       i_valid, i_rdata, i_err, e.data, e.err);
            end
          end
        end
      end
    end
  end

  // Return a memory response at the next falling edge, expecting it on the given side.
  task automatic mem_respond(input logic side, input logic [63:0] data, input logic err,
                             input logic expect_fwd);
    exp_t e;
    @(negedge clk);
    if (expect_fwd) begin
      e.side = side; e.data = data; e.err = err;
      sb_q.push_back(e);
    end
    mem_valid = 1'b1;
    mem_rdata = data;
    mem_err   = err;
    i_req     = 1'b0;
    d_req     = 1'b0;
  endtask

  task automatic mem_release();
    @(negedge clk);
    mem_valid = 1'b0;
    mem_rdata = '0;
    mem_err   = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1; mem_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || i_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got req=%0b ig=%0b dg=%0b addr=%h exp all 0",
               mem_req, i_gnt, d_gnt, mem_addr);
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0; mem_valid = 1'b0; mem_ready = 1'b0; resetn = 1'b1;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50; mem_ready = 1'b1;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_gnt got d_gnt=%0b exp 1", d_gnt);
    end
    @(negedge clk);
    d_req = 1'b0; mem_valid = 1'b1; mem_rdata = 64'hdead_beef_0000_0001; resetn = 1'b0;
    #1;
    checks++;
    if (d_valid !== 1'b0 || d_rdata !== 64'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_busy got d_valid=%0b d_rdata=%h mem_req=%0b exp 0",
               d_valid, d_rdata, mem_req);
    end
    @(negedge clk);
    resetn = 1'b1; mem_valid = 1'b0; mem_rdata = '0; i_req = 1'b1; i_addr = 32'h60;
    #1;
    checks++;
    if (i_gnt !== 1'b1 || mem_addr !== 32'h60) begin
      errors++;
      $display("FAIL reset_idle_gnt got i_gnt=%0b addr=%h exp 1 00000060", i_gnt, mem_addr);
    end
    mem_respond(1'b0, 64'h0000_0000_0000_0060, 1'b0, 1'b1);
    mem_release();
  endtask

  task automatic test_lone_fetch();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1000; mem_ready = 1'b1;
    #1;
    checks++;
    if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h1000 ||
        mem_we !== 1'b0 || mem_wstrb !== 8'h00) begin
      errors++;
      $display("FAIL lone_issue got ig=%0b dg=%0b req=%0b addr=%h we=%0b strb=%h exp 1 0 1 00001000 0 00",
               i_gnt, d_gnt, mem_req, mem_addr, mem_we, mem_wstrb);
    end
    @(negedge clk);
    i_req = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || i_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lone_busy got req=%0b ig=%0b exp 0 0", mem_req, i_gnt);
    end
    mem_respond(1'b0, 64'h0000_0013_0000_0013, 1'b0, 1'b1);
    mem_release();
  endtask

  task automatic test_conflict();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h1100;
    d_req = 1'b1; d_addr = 32'h2000; d_we = 1'b1; d_wstrb = 8'hFF; d_wdata = 64'h1122_3344_5566_7788;
    #1;
    checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h2000 ||
        mem_wstrb !== 8'hFF || mem_wdata !== 64'h1122_3344_5566_7788) begin
      errors++;
      $display("FAIL conflict_issue got dg=%0b ig=%0b we=%0b addr=%h strb=%h wdata=%h",
               d_gnt, i_gnt, mem_we, mem_addr, mem_wstrb, mem_wdata);
    end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    #1;
    checks++;
    if (i_gnt !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL conflict_busy got ig=%0b req=%0b exp 0 0", i_gnt, mem_req);
    end
    @(negedge clk);
    sb_q.push_back('{side: 1'b1, data: 64'h0, err: 1'b0});
    mem_valid = 1'b1; mem_rdata = 64'h0; mem_err = 1'b0;
    #1;
    checks++;
    if (i_gnt !== 1'b0) begin
      errors++;
      $display("FAIL conflict_bubble got ig=%0b exp 0", i_gnt);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    checks++;
    if (i_gnt !== 1'b1 || mem_addr !== 32'h1100 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL conflict_i_after got ig=%0b addr=%h we=%0b exp 1 00001100 0",
               i_gnt, mem_addr, mem_we);
    end
    mem_respond(1'b0, 64'h0000_0000_0000_1100, 1'b0, 1'b1);
    mem_release();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order;
    logic       side;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;
`else
    exp_order = 4'b1111;
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_valid = 1'b0;
      i_req = 1'b1; i_addr = 32'h3000 + 32'(k * 8);
      d_req = 1'b1; d_addr = 32'h4000 + 32'(k * 8); d_we = 1'b0;
      #1;
      side = d_gnt;
      checks++;
      if ((i_gnt ^ d_gnt) !== 1'b1 || side !== exp_order[k]) begin
        errors++;
        $display("FAIL rr_order[%0d] got ig=%0b dg=%0b exp d_side=%0b", k, i_gnt, d_gnt, exp_order[k]);
      end
      @(negedge clk);
      sb_q.push_back('{side: side, data: 64'hA000 + 64'(k), err: 1'b0});
      mem_valid = 1'b1; mem_rdata = 64'hA000 + 64'(k);
    end
    @(negedge clk);
    mem_valid = 1'b0; mem_rdata = '0; i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h5000;
    #1;
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_issue got ig=%0b exp 1", i_gnt);
    end
    @(negedge clk);
    i_req = 1'b0; i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_valid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    checks++;
    if (i_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got i_valid=%0b exp 0", i_valid);
    end
    @(negedge clk);
    mem_valid = 1'b0; i_req = 1'b1; i_addr = 32'h5008;
    #1;
    checks++;
    if (i_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_regrant got ig=%0b exp 1", i_gnt);
    end
    mem_respond(1'b0, 64'h0000_0000_0000_5008, 1'b0, 1'b1);
    @(negedge clk);
    mem_valid = 1'b0; i_req = 1'b1; i_addr = 32'h5010;
    @(negedge clk);
    i_req = 1'b0; i_flush = 1'b1; mem_valid = 1'b1; mem_rdata = 64'hBAD1;
    #1;
    checks++;
    if (i_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle got i_valid=%0b exp 0", i_valid);
    end
    @(negedge clk);
    i_flush = 1'b0; mem_valid = 1'b0; d_req = 1'b1; d_addr = 32'h5100;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_after got dg=%0b exp 1", d_gnt);
    end
    mem_respond(1'b1, 64'h0000_0000_0000_5100, 1'b0, 1'b1);
    mem_release();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000; mem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (d_gnt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h6000) begin
        errors++;
        $display("FAIL bp_hold[%0d] got dg=%0b req=%0b addr=%h exp 0 1 00006000",
                 c, d_gnt, mem_req, mem_addr);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got dg=%0b exp 1", d_gnt);
    end
    mem_respond(1'b1, 64'hEEEE_0000_0000_6000, 1'b1, 1'b1);
    mem_release();
  endtask

  initial begin
    resetn = 1'b0; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    test_reset();
    test_lone_fetch();
    test_conflict();
    test_round_robin();
    test_flush();
    test_backpressure();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
